// File: rtl/out_channel_checker.sv
// Receiving end of the program out channel: loads an expected word sequence, captures
// the emitted stream, compares it in order and reports pass/fail when the program halts.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 200,
    parameter int NExpect            = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_valid,
    input  logic [MemoryElementWidth-1:0] exp_data,
    output logic                          exp_ready,
    input  logic                          start,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          out_ready,
    input  logic                          halt,
    input  logic                          clear,
    input  logic [MemoryElementWidth-1:0] rd_addr,
    output logic [MemoryElementWidth-1:0] rd_data,
    output logic [MemoryElementWidth-1:0] out_count,
    output logic                          mismatch,
    output logic [MemoryElementWidth-1:0] mismatch_index,
    output logic                          overflow,
    output logic                          finished,
    output logic                          success
);

    localparam int W     = MemoryElementWidth;
    localparam int CapAw = (NOut > 1) ? $clog2(NOut) : 1;
    localparam int ExpAw = (NExpect > 1) ? $clog2(NExpect) : 1;
    localparam logic [W-1:0] NOutW    = W'(NOut);
    localparam logic [W-1:0] NExpectW = W'(NExpect);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DONE
    } stateT;

    stateT        state, stateNext;
    logic [W-1:0] expCount, expCountNext;
    logic [W-1:0] outCount, outCountNext;
    logic [W-1:0] mismatchIndexR, mismatchIndexNext;
    logic         mismatchR, mismatchNext;
    logic         overflowR, overflowNext;
    logic         finishedR, finishedNext;
    logic         successR, successNext;
    logic         expWrite, capWrite;
    logic [W-1:0] expWord;
    logic [W-1:0] rdDataR;

    // The memories carry no reset so the capture store can map onto block RAM;
    // the counts alone decide which entries are meaningful.
    logic [W-1:0] expMem [NExpect];
    logic [W-1:0] capMem [NOut];

    // exp_ready is also gated by reset so every output reads 0 while reset is held.
    assign exp_ready      = reset && (state == LOAD) && (expCount < NExpectW);
    assign out_ready      = (state == RUN);
    assign expWord        = expMem[outCount[ExpAw-1:0]];
    assign rd_data        = rdDataR;
    assign out_count      = outCount;
    assign mismatch       = mismatchR;
    assign mismatch_index = mismatchIndexR;
    assign overflow       = overflowR;
    assign finished       = finishedR;
    assign success        = successR;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= LOAD;
            expCount       <= '0;
            outCount       <= '0;
            mismatchIndexR <= '0;
            mismatchR      <= 1'b0;
            overflowR      <= 1'b0;
            finishedR      <= 1'b0;
            successR       <= 1'b0;
        end else begin
            state          <= stateNext;
            expCount       <= expCountNext;
            outCount       <= outCountNext;
            mismatchIndexR <= mismatchIndexNext;
            mismatchR      <= mismatchNext;
            overflowR      <= overflowNext;
            finishedR      <= finishedNext;
            successR       <= successNext;
        end
    end

    // A word accepted in the halt cycle is folded into the verdict through the *Next values.
    always_comb begin
        stateNext         = state;
        expCountNext      = expCount;
        outCountNext      = outCount;
        mismatchIndexNext = mismatchIndexR;
        mismatchNext      = mismatchR;
        overflowNext      = overflowR;
        finishedNext      = finishedR;
        successNext       = successR;
        expWrite          = 1'b0;
        capWrite          = 1'b0;
        unique case (state)
            LOAD: begin
                if (exp_valid && exp_ready) begin
                    expWrite     = 1'b1;
                    expCountNext = expCount + 1'b1;
                end
                if (start) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (out_valid) begin
                    if (outCount < NOutW) begin
                        capWrite     = 1'b1;
                        outCountNext = outCount + 1'b1;
                    end else begin
                        overflowNext = 1'b1;
                    end
                    if ((outCount < expCount) && (out_data != expWord)) begin
                        mismatchNext = 1'b1;
                        if (!mismatchR) begin
                            mismatchIndexNext = outCount;
                        end
                    end
                end
                if (halt) begin
                    stateNext    = DONE;
                    finishedNext = 1'b1;
                    successNext  = !mismatchNext && !overflowNext && (outCountNext == expCount);
                end
            end
            DONE: begin
                if (clear) begin
                    stateNext         = LOAD;
                    expCountNext      = '0;
                    outCountNext      = '0;
                    mismatchIndexNext = '0;
                    mismatchNext      = 1'b0;
                    overflowNext      = 1'b0;
                    finishedNext      = 1'b0;
                    successNext       = 1'b0;
                end
            end
            default: begin
                stateNext = LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (expWrite) begin
            expMem[expCount[ExpAw-1:0]] <= exp_data;
        end
        if (capWrite) begin
            capMem[outCount[CapAw-1:0]] <= out_data;
        end
    end

    // Readback is available in every state; addresses past the capture store read as 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdDataR <= '0;
        end else if (rd_addr < NOutW) begin
            rdDataR <= capMem[rd_addr[CapAw-1:0]];
        end else begin
            rdDataR <= '0;
        end
    end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed and randomized checks of out_channel_checker against a list-based model
// that derives the verdict directly from the expected and emitted word sequences.
module tb_out_channel_checker;

    localparam int W    = 12;
    localparam int NOUT = 8;
    localparam int NEXP = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_data = '0;
    logic         exp_ready;
    logic         start = 1'b0;
    logic         out_valid = 1'b0;
    logic [W-1:0] out_data = '0;
    logic         out_ready;
    logic         halt = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] rd_addr = '0;
    logic [W-1:0] rd_data;
    logic [W-1:0] out_count;
    logic         mismatch;
    logic [W-1:0] mismatch_index;
    logic         overflow;
    logic         finished;
    logic         success;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] expQ[$];
    logic [W-1:0] emitQ[$];

    out_channel_checker #(
        .MemoryElementWidth(W),
        .NOut(NOUT),
        .NExpect(NEXP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .exp_valid(exp_valid),
        .exp_data(exp_data),
        .exp_ready(exp_ready),
        .start(start),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .halt(halt),
        .clear(clear),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .out_count(out_count),
        .mismatch(mismatch),
        .mismatch_index(mismatch_index),
        .overflow(overflow),
        .finished(finished),
        .success(success)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".exp_ready"}, exp_ready, 0);
        checkOutput({tag, ".out_ready"}, out_ready, 0);
        checkOutput({tag, ".rd_data"}, rd_data, 0);
        checkOutput({tag, ".out_count"}, out_count, 0);
        checkOutput({tag, ".mismatch"}, mismatch, 0);
        checkOutput({tag, ".mismatch_index"}, mismatch_index, 0);
        checkOutput({tag, ".overflow"}, overflow, 0);
        checkOutput({tag, ".finished"}, finished, 0);
        checkOutput({tag, ".success"}, success, 0);
    endtask

    // Offers every word of expQ back to back, optionally raising start with the last one.
    task automatic applyStimulus(input bit startWithLast);
        for (int i = 0; i < expQ.size(); i++) begin
            exp_valid = 1'b1;
            exp_data  = expQ[i];
            start     = startWithLast && (i == expQ.size() - 1);
            tick();
        end
        exp_valid = 1'b0;
        if (!startWithLast || expQ.size() == 0) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        checkOutput("run.out_ready", out_ready, 1);
        checkOutput("run.exp_ready", exp_ready, 0);
    endtask

    // Emits emitQ, checking the sticky flags right after each word is accepted.
    task automatic emitWords(input bit haltWithLast, input bit gaps);
        bit mm = 1'b0;
        for (int i = 0; i < emitQ.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                out_valid = 1'b0;
                tick();
            end
            out_valid = 1'b1;
            out_data  = emitQ[i];
            halt      = haltWithLast && (i == emitQ.size() - 1);
            tick();
            out_valid = 1'b0;
            halt      = 1'b0;
            if (i < expQ.size() && emitQ[i] != expQ[i]) mm = 1'b1;
            checkOutput("emit.mismatch", mismatch, mm);
            checkOutput("emit.overflow", overflow, i >= NOUT);
            checkOutput("emit.out_count", out_count, (i + 1 < NOUT) ? i + 1 : NOUT);
        end
        if (!haltWithLast || emitQ.size() == 0) begin
            checkOutput("emit.finished_low", finished, 0);
            halt = 1'b1;
            tick();
            halt = 1'b0;
        end
    endtask

    task automatic checkDone();
        int  n = emitQ.size();
        int  e = expQ.size();
        int  stored = (n < NOUT) ? n : NOUT;
        bit  ovf = (n > NOUT);
        bit  mm = 1'b0;
        int  mi = 0;
        for (int i = 0; i < n && i < e; i++) begin
            if (!mm && emitQ[i] != expQ[i]) begin
                mm = 1'b1;
                mi = i;
            end
        end
        checkOutput("done.finished", finished, 1);
        checkOutput("done.success", success, !mm && !ovf && (stored == e));
        checkOutput("done.out_count", out_count, stored);
        checkOutput("done.mismatch", mismatch, mm);
        checkOutput("done.mismatch_index", mismatch_index, mi);
        checkOutput("done.overflow", overflow, ovf);
        checkOutput("done.out_ready", out_ready, 0);
        checkOutput("done.exp_ready", exp_ready, 0);
        for (int i = 0; i < stored; i++) begin
            rd_addr = W'(i);
            tick();
            checkOutput("done.readback", rd_data, emitQ[i]);
        end
        rd_addr = W'(NOUT);
        tick();
        checkOutput("done.readback_oob", rd_data, 0);
        rd_addr = '0;
    endtask

    task automatic clearDut();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear.finished", finished, 0);
        checkOutput("clear.success", success, 0);
        checkOutput("clear.out_count", out_count, 0);
        checkOutput("clear.mismatch", mismatch, 0);
        checkOutput("clear.overflow", overflow, 0);
        checkOutput("clear.exp_ready", exp_ready, 1);
    endtask

    initial begin
        int e;
        int n;
        $display("[TB] start");

        // Reset state, then halt/clear ignored in LOAD.
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b1;
        #1;
        checkOutput("reset.exp_ready_release", exp_ready, 1);
        halt  = 1'b1;
        clear = 1'b1;
        tick();
        halt  = 1'b0;
        clear = 1'b0;
        checkOutput("load.halt_ignored", finished, 0);
        checkOutput("load.still_load", exp_ready, 1);

        // Matching run, then a word offered in DONE must be ignored.
        expQ  = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
        emitQ = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
        applyStimulus(1'b0);
        emitWords(1'b0, 1'b0);
        checkDone();
        rd_addr = 12'd4;
        tick();
        checkOutput("t1.readback4", rd_data, 2);
        out_valid = 1'b1;
        out_data  = 12'd7;
        tick();
        out_valid = 1'b0;
        checkOutput("t1.done_ignores_out", out_count, 5);
        clearDut();

        // Mismatch at index 2.
        expQ  = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
        emitQ = '{12'd1, 12'd2, 12'd3, 12'd1, 12'd2};
        applyStimulus(1'b0);
        emitWords(1'b0, 1'b0);
        checkDone();
        clearDut();

        // Short stream: count mismatch only.
        expQ  = '{12'd5, 12'd6, 12'd7};
        emitQ = '{12'd5, 12'd6};
        applyStimulus(1'b1);
        emitWords(1'b0, 1'b0);
        checkDone();
        clearDut();

        // Fill the expected memory, offer one more, then overflow the capture store.
        expQ = '{12'd10, 12'd11, 12'd12, 12'd13, 12'd14, 12'd15};
        for (int i = 0; i < NEXP; i++) begin
            exp_valid = 1'b1;
            exp_data  = expQ[i];
            tick();
        end
        checkOutput("full.exp_ready", exp_ready, 0);
        exp_data = 12'd99;
        tick();
        exp_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        emitQ = '{12'd10, 12'd11, 12'd12, 12'd13, 12'd14, 12'd15, 12'd16, 12'd17, 12'd18};
        emitWords(1'b0, 1'b0);
        checkDone();
        clearDut();

        // Last word arrives together with halt.
        expQ  = '{12'hABC, 12'h123, 12'hFFF};
        emitQ = '{12'hABC, 12'h123, 12'hFFF};
        applyStimulus(1'b0);
        emitWords(1'b1, 1'b0);
        checkDone();
        clearDut();

        // Reset mid-run aborts; nothing restarts until a new load and start.
        expQ  = '{12'd1, 12'd2, 12'd3};
        emitQ = '{12'd1, 12'd2};
        applyStimulus(1'b0);
        for (int i = 0; i < 2; i++) begin
            out_valid = 1'b1;
            out_data  = emitQ[i];
            tick();
        end
        out_valid = 1'b0;
        checkOutput("abort.pre_count", out_count, 2);
        reset = 1'b0;
        #1;
        checkAllZero("abort");
        tick();
        reset = 1'b1;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        checkOutput("abort.no_restart", out_count, 0);
        checkOutput("abort.in_load", exp_ready, 1);
        expQ  = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
        emitQ = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
        applyStimulus(1'b0);
        emitWords(1'b0, 1'b0);
        checkDone();
        clearDut();

        // Randomized runs: lengths, contents, start/halt alignment and idle gaps.
        for (int iter = 0; iter < 16; iter++) begin
            expQ.delete();
            emitQ.delete();
            e = $urandom_range(0, NEXP);
            n = ($urandom_range(0, 1) == 1) ? e : $urandom_range(0, NOUT + 2);
            for (int i = 0; i < e; i++) expQ.push_back(W'($urandom_range(0, 4095)));
            for (int i = 0; i < n; i++) begin
                if (i < e && $urandom_range(0, 4) != 0) emitQ.push_back(expQ[i]);
                else emitQ.push_back(W'($urandom_range(0, 4095)));
            end
            applyStimulus($urandom_range(0, 1) == 1);
            emitWords($urandom_range(0, 1) == 1, 1'b1);
            checkDone();
            clearDut();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
